// File: rtl/saradc_pkg.sv
// Shared types and widths for the SAR ADC sequencer slice.
package saradc_pkg;

   localparam int RES_W  = 10;
   localparam int AVG_W  = 2;
   localparam int SAMP_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAL,
      ST_CONV,
      ST_ACC,
      ST_HOLD
   } state_t;

   function automatic logic [SAMP_W-1:0] samp_count(input logic [AVG_W-1:0] avg);
      return SAMP_W'(1) << avg;
   endfunction

endpackage

// File: rtl/saradc_seq_if.sv
// ADC handshake and averaged-sample stream between the sequencer and its neighbours.
interface saradc_seq_if #(
   parameter int RES_W = saradc_pkg::RES_W
) ();
   logic             adc_en;
   logic             adc_cal;
   logic             adc_valid;
   logic [RES_W-1:0] adc_result;
   logic [RES_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output adc_en, adc_cal, out_data, out_valid,
      input  adc_valid, adc_result, out_ready
   );

   modport slave (
      input  adc_en, adc_cal, out_data, out_valid,
      output adc_valid, adc_result, out_ready
   );
endinterface

// File: rtl/saradc_acc.sv
// Burst accumulator; avg_out is the running sum including the current sample,
// shifted down by the averaging code.
module saradc_acc #(
   parameter int RES_W = saradc_pkg::RES_W
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        clr,
   input  logic                        add,
   input  logic [RES_W-1:0]            sample,
   input  logic [saradc_pkg::AVG_W-1:0] avg,
   output logic [RES_W-1:0]            avg_out
);
   logic [RES_W+2:0] acc_q;
   logic [RES_W+2:0] sum;

   assign sum     = acc_q + {3'b000, sample};
   // At most 2^avg samples are summed, so the shifted sum always fits RES_W.
   assign avg_out = RES_W'(sum >> avg);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (add) begin
         acc_q <= sum;
      end
   end
endmodule

// File: rtl/saradc_seq.sv
// SAR ADC conversion sequencer: calibration, averaged bursts, timeout and interval pacing.
//
// state | meaning
// IDLE  | waiting for start or continuous mode
// CAL   | calibration conversion, result discarded
// CONV  | sample conversion in flight
// ACC   | add captured sample, pick next sample or finish
// HOLD  | interval wait before returning to IDLE
module saradc_seq #(
   parameter int TIMEOUT = 255,
   parameter int RES_W   = saradc_pkg::RES_W
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         cfg_enable,
   input  logic                         cfg_cont,
   input  logic [saradc_pkg::AVG_W-1:0] cfg_avg,
   input  logic [15:0]                  cfg_interval,
   input  logic                         start,
   input  logic                         cal_req,
   input  logic                         clr_err,
   output logic                         busy,
   output logic                         err_timeout,
   output logic                         err_overrun,
   saradc_seq_if.master                 bus
);
   import saradc_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t             state, state_nxt;
   logic [TW-1:0]      tmo_cnt;
   logic [15:0]        hold_cnt, interval_q;
   logic [AVG_W-1:0]   avg_q;
   logic [SAMP_W-1:0]  samp_left;
   logic [RES_W-1:0]   sample_q, avg_out, out_data_q;
   logic               adc_en_q, adc_cal_q, out_valid_q, cal_pending;
   logic               conv_done, tmo_hit, last_samp, in_conv;
   logic               adc_en_d, adc_cal_d, idle_exit, result_load;
   logic               acc_add, acc_clr, hold_load, tmo_evt;

   // Only a valid seen while the ADC is enabled counts as a finished conversion.
   assign conv_done = bus.adc_valid & adc_en_q;
   assign tmo_hit   = (tmo_cnt <= TW'(1)) & ~conv_done;
   assign last_samp = samp_left == SAMP_W'(1);
   assign in_conv   = (state == ST_CAL) || (state == ST_CONV);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!cfg_enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start || cfg_cont) state_nxt = cal_pending ? ST_CAL : ST_CONV;
            ST_CAL:  if (conv_done) state_nxt = ST_CONV;
                     else if (tmo_hit) state_nxt = ST_HOLD;
            ST_CONV: if (conv_done) state_nxt = ST_ACC;
                     else if (tmo_hit) state_nxt = ST_HOLD;
            ST_ACC:  state_nxt = last_samp ? ST_HOLD : ST_CONV;
            ST_HOLD: if (hold_cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy        = state != ST_IDLE;
      idle_exit   = (state == ST_IDLE) && (state_nxt != ST_IDLE);
      // The first CONV cycle after CAL keeps the ADC disabled to separate the two conversions.
      adc_en_d    = (state_nxt == ST_CAL) || ((state_nxt == ST_CONV) && (state != ST_CAL));
      adc_cal_d   = state_nxt == ST_CAL;
      result_load = (state == ST_ACC) && (state_nxt == ST_HOLD);
      acc_add     = (state == ST_ACC) && cfg_enable;
      acc_clr     = (state == ST_IDLE) || (state == ST_HOLD);
      hold_load   = (state_nxt == ST_HOLD) && (state != ST_HOLD);
      tmo_evt     = in_conv && cfg_enable && tmo_hit;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         adc_en_q    <= 1'b0;
         adc_cal_q   <= 1'b0;
         avg_q       <= '0;
         interval_q  <= '0;
         samp_left   <= '0;
         sample_q    <= '0;
         tmo_cnt     <= '0;
         hold_cnt    <= '0;
         cal_pending <= 1'b1;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         adc_en_q  <= adc_en_d;
         adc_cal_q <= adc_cal_d;

         if (idle_exit) begin
            avg_q      <= cfg_avg;
            interval_q <= cfg_interval;
            samp_left  <= samp_count(cfg_avg);
         end else if (state == ST_ACC) begin
            samp_left  <= samp_left - SAMP_W'(1);
         end

         if ((state == ST_CONV) && conv_done) sample_q <= bus.adc_result;

         if ((state_nxt != state) || !in_conv) tmo_cnt <= TW'(TIMEOUT);
         else                                  tmo_cnt <= tmo_cnt - TW'(1);

         if (hold_load)                                hold_cnt <= interval_q;
         else if ((state == ST_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - 16'd1;

         if (cal_req)                              cal_pending <= 1'b1;
         else if ((state == ST_CAL) && conv_done)  cal_pending <= 1'b0;

         if (result_load) begin
            out_data_q  <= avg_out;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         err_overrun <= (result_load & out_valid_q & ~bus.out_ready) | (err_overrun & ~clr_err);
         err_timeout <= tmo_evt | (err_timeout & ~clr_err);
      end
   end

   saradc_acc #(.RES_W(RES_W)) u_acc (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (acc_clr),
      .add     (acc_add),
      .sample  (sample_q),
      .avg     (avg_q),
      .avg_out (avg_out)
   );

   assign bus.adc_en    = adc_en_q;
   assign bus.adc_cal   = adc_cal_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_saradc_seq.sv
// Bench for saradc_seq: behavioural ADC, vector table of bursts, scoreboard on the output stream.
module tb_saradc_seq;
   localparam int RW      = 10;
   localparam int ADC_LAT = 3;

   logic        clk = 1'b0, rstn = 1'b0;
   logic        cfg_enable = 1'b0, cfg_cont = 1'b0;
   logic [1:0]  cfg_avg = 2'd0;
   logic [15:0] cfg_interval = 16'd0;
   logic        start = 1'b0, cal_req = 1'b0, clr_err = 1'b0;
   logic        busy, err_timeout, err_overrun;

   saradc_seq_if #(.RES_W(RW)) bus ();

   saradc_seq #(.TIMEOUT(255), .RES_W(RW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .cfg_enable   (cfg_enable),
      .cfg_cont     (cfg_cont),
      .cfg_avg      (cfg_avg),
      .cfg_interval (cfg_interval),
      .start        (start),
      .cal_req      (cal_req),
      .clr_err      (clr_err),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]         avg;
      logic [7:0][RW-1:0] s;
      logic [RW-1:0]      req;
      int                 cal;
   } vec_t;

   vec_t          vecs[10];
   int            n_vec = 0, n_err = 0;
   logic [RW-1:0] samp_q[$];
   logic [RW-1:0] exp_q[$];
   bit            adc_mute = 1'b0;
   int            en_cnt = 0, cal_cnt = 0, conv_cnt = 0, low_run = 0, last_gap = 0;
   logic          en_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] avg, input int cal, input logic [RW-1:0] req,
                               input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                               input logic [RW-1:0] s2, input logic [RW-1:0] s3,
                               input logic [RW-1:0] s4, input logic [RW-1:0] s5,
                               input logic [RW-1:0] s6, input logic [RW-1:0] s7);
      vec_t v;
      v.avg = avg; v.cal = cal; v.req = req;
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
      v.s[4] = s4; v.s[5] = s5; v.s[6] = s6; v.s[7] = s7;
      return v;
   endfunction

   // ADC model, conversion monitor and output scoreboard, all on the falling edge.
   always @(negedge clk) begin
      if (bus.adc_en === 1'b1 && !adc_mute) begin
         en_cnt++;
         if (en_cnt == ADC_LAT) begin
            bus.adc_valid = 1'b1;
            if (bus.adc_cal)            bus.adc_result = 10'h2AA;
            else if (samp_q.size() > 0) bus.adc_result = samp_q.pop_front();
            else                        bus.adc_result = '0;
         end else begin
            bus.adc_valid = 1'b0;
         end
      end else begin
         en_cnt = 0;
         bus.adc_valid = 1'b0;
      end

      if (bus.adc_en === 1'b1 && en_prev !== 1'b1) begin
         if (bus.adc_cal) cal_cnt++;
         else             conv_cnt++;
         last_gap = low_run;
      end
      low_run = (bus.adc_en === 1'b1) ? 0 : low_run + 1;
      en_prev = bus.adc_en;

      if (rstn && bus.out_valid === 1'b1 && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got out_data %0h, no result expected", bus.out_data);
         end else begin
            chk("sb_out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk(name, 32'(busy), 0);
   endtask

   task automatic run_vec(input int i);
      cfg_avg = vecs[i].avg;
      for (int k = 0; k < (1 << vecs[i].avg); k++) samp_q.push_back(vecs[i].s[k]);
      exp_q.push_back(vecs[i].req);
      cal_cnt  = 0;
      conv_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      wait_idle("vec_done");
      chk("vec_result_seen", 32'(exp_q.size()), 0);
      chk("vec_conv_count", 32'(conv_cnt), 32'(1 << vecs[i].avg));
      chk("vec_cal_count", 32'(cal_cnt), 32'(vecs[i].cal));
      chk("vec_err_flags", {30'd0, err_timeout, err_overrun}, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int ctmp;
      bus.adc_valid  = 1'b0;
      bus.adc_result = '0;
      bus.out_ready  = 1'b1;

      vecs[0] = mk(2'd0, 1, 10'h155, 10'h155, 0, 0, 0, 0, 0, 0, 0);
      vecs[1] = mk(2'd3, 0, 10'h37F, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000);
      vecs[2] = mk(2'd1, 0, 10'h001, 10'h001, 10'h002, 0, 0, 0, 0, 0, 0);
      vecs[3] = mk(2'd2, 0, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 0, 0, 0, 0);
      vecs[4] = mk(2'd2, 0, 10'h0E0, 10'h100, 10'h200, 10'h080, 10'h001, 0, 0, 0, 0);
      vecs[5] = mk(2'd1, 0, 10'h3FE, 10'h3FF, 10'h3FE, 0, 0, 0, 0, 0, 0);
      vecs[6] = mk(2'd0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 0, 0);
      vecs[7] = mk(2'd2, 0, 10'h004, 10'h004, 10'h004, 10'h004, 10'h004, 0, 0, 0, 0);
      vecs[8] = mk(2'd1, 1, 10'h200, 10'h100, 10'h300, 0, 0, 0, 0, 0, 0);
      vecs[9] = mk(2'd0, 0, 10'h2A5, 10'h2A5, 0, 0, 0, 0, 0, 0, 0);

      repeat (3) tick();
      rstn = 1'b1;
      tick();
      chk("rst_adc_en", 32'(bus.adc_en), 0);
      chk("rst_adc_cal", 32'(bus.adc_cal), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err_timeout", 32'(err_timeout), 0);
      chk("rst_err_overrun", 32'(err_overrun), 0);

      cfg_enable = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) run_vec(i);

      // ADC silent: conversion abandoned after TIMEOUT cycles
      adc_mute = 1'b1;
      cfg_avg  = 2'd0;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (bus.adc_en && n < 600) begin
         n++;
         tick();
      end
      chk("tmo_en_cycles", 32'(n), 255);
      chk("tmo_err_set", 32'(err_timeout), 1);
      chk("tmo_no_out_valid", 32'(bus.out_valid), 0);
      wait_idle("tmo_idle");
      adc_mute = 1'b0;
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("tmo_err_cleared", 32'(err_timeout), 0);

      // Enable dropped in the second CONV of a 4-sample burst
      cfg_avg = 2'd2;
      repeat (4) samp_q.push_back(10'h3FF);
      conv_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(conv_cnt == 2 && bus.adc_en) && n < 200) begin
         tick();
         n++;
      end
      chk("dis_reach_conv2", 32'(conv_cnt == 2 && bus.adc_en), 1);
      cfg_enable = 1'b0;
      tick();
      chk("dis_adc_en", 32'(bus.adc_en), 0);
      chk("dis_busy", 32'(busy), 0);
      n = 0;
      repeat (5) begin
         tick();
         if (bus.out_valid) n++;
      end
      chk("dis_no_out_valid", 32'(n), 0);
      samp_q.delete();
      cfg_enable = 1'b1;
      tick();
      run_vec(7);

      // Continuous bursts with a stalled consumer
      cfg_interval  = 16'd10;
      cfg_avg       = 2'd0;
      bus.out_ready = 1'b0;
      samp_q.push_back(10'h0AA);
      samp_q.push_back(10'h0BB);
      cfg_cont = 1'b1;
      n = 0;
      while (!bus.out_valid && n < 300) begin
         tick();
         n++;
      end
      chk("ovr_first_data", 32'(bus.out_data), 32'h0AA);
      chk("ovr_flag_before", 32'(err_overrun), 0);
      n = 0;
      while (!err_overrun && n < 300) begin
         tick();
         n++;
      end
      chk("ovr_flag_set", 32'(err_overrun), 1);
      chk("ovr_newest_data", 32'(bus.out_data), 32'h0BB);
      chk("ovr_out_valid", 32'(bus.out_valid), 1);
      chk("ovr_gap_ge_10", 32'(last_gap >= 10), 1);
      cfg_cont = 1'b0;
      exp_q.push_back(10'h0BB);
      bus.out_ready = 1'b1;
      wait_idle("ovr_idle");
      tick();
      chk("ovr_drained", 32'(exp_q.size()), 0);
      chk("ovr_valid_cleared", 32'(bus.out_valid), 0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("ovr_err_cleared", 32'(err_overrun), 0);

      // cal_req and a stray start during HOLD
      cfg_avg = 2'd1;
      samp_q.push_back(10'h010);
      samp_q.push_back(10'h020);
      exp_q.push_back(10'h018);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 300) begin
         tick();
         n++;
      end
      chk("hold_result_valid", 32'(bus.out_valid), 1);
      ctmp = conv_cnt;
      cal_req = 1'b1; start = 1'b1; tick(); cal_req = 1'b0; start = 1'b0;
      wait_idle("hold_idle");
      repeat (3) tick();
      chk("hold_start_ignored", 32'(conv_cnt), 32'(ctmp));
      chk("hold_result_seen", 32'(exp_q.size()), 0);
      run_vec(8);
      run_vec(9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
